// File: rtl/cpu_memory_pkg.sv
// Shared definitions for the mox125 memory-access stage: pipeline control bit
// positions, datapath widths and the latched-instruction payload.
package cpu_memory_pkg;

  localparam int unsigned PCB_WIDTH     = 6;
  localparam int unsigned PCB_WA        = 0;
  localparam int unsigned PCB_WB        = 1;
  localparam int unsigned PCB_RM        = 2;
  localparam int unsigned PCB_WM        = 3;
  localparam int unsigned REG_IDX_WIDTH = 4;
  localparam int unsigned DATA_WIDTH    = 32;

  // Everything write-back needs from one instruction
  typedef struct packed {
    logic [PCB_WIDTH-1:0]     pcb;
    logic [REG_IDX_WIDTH-1:0] idx0;
    logic [REG_IDX_WIDTH-1:0] idx1;
    logic [DATA_WIDTH-1:0]    r0;
    logic [DATA_WIDTH-1:0]    r1;
  } mem_instr_t;

  function automatic logic is_mem_op(input logic [PCB_WIDTH-1:0] pcb);
    return pcb[PCB_RM] | pcb[PCB_WM];
  endfunction

endpackage

// File: rtl/cpu_memory_wb_master.sv
// Wishbone classic single-transfer master: IDLE/BUS handshake FSM holding the
// request stable until acknowledge.
module cpu_memory_wb_master
  import cpu_memory_pkg::*;
#(
  parameter int unsigned AW = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req,
  input  logic                  we,
  input  logic [AW-1:0]         adr,
  input  logic [DATA_WIDTH-1:0] dat,
  output logic                  done_c,
  output logic [DATA_WIDTH-1:0] rdata_c,
  output logic [AW-1:0]         dwb_adr_o,
  output logic [DATA_WIDTH-1:0] dwb_dat_o,
  input  logic [DATA_WIDTH-1:0] dwb_dat_i,
  output logic                  dwb_we_o,
  output logic                  dwb_cyc_o,
  output logic                  dwb_stb_o,
  output logic [3:0]            dwb_sel_o,
  input  logic                  dwb_ack_i
);

  typedef enum logic {IDLE = 1'b0, BUS = 1'b1} bus_state_e;

  bus_state_e            state, state_n;
  logic                  cyc_n, stb_n, we_n;
  logic [AW-1:0]         adr_n;
  logic [DATA_WIDTH-1:0] dat_n;

  // State and bus output registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      dwb_cyc_o <= 1'b0;
      dwb_stb_o <= 1'b0;
      dwb_we_o  <= 1'b0;
      dwb_sel_o <= 4'b0000;
      dwb_adr_o <= '0;
      dwb_dat_o <= '0;
    end else begin
      state     <= state_n;
      dwb_cyc_o <= cyc_n;
      dwb_stb_o <= stb_n;
      dwb_we_o  <= we_n;
      dwb_sel_o <= {4{cyc_n}};
      dwb_adr_o <= adr_n;
      dwb_dat_o <= dat_n;
    end
  end

  // Next state and next bus outputs
  always_comb begin
    state_n = state;
    cyc_n   = dwb_cyc_o;
    stb_n   = dwb_stb_o;
    we_n    = dwb_we_o;
    adr_n   = dwb_adr_o;
    dat_n   = dwb_dat_o;
    done_c  = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_n = BUS;
          cyc_n   = 1'b1;
          stb_n   = 1'b1;
          we_n    = we;
          adr_n   = adr;
          dat_n   = dat;
        end
      end
      BUS: begin
        if (dwb_ack_i) begin
          state_n = IDLE;
          cyc_n   = 1'b0;
          stb_n   = 1'b0;
          done_c  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rdata_c = dwb_dat_i;

endmodule

// File: rtl/cpu_memory.sv
// mox125 memory-access stage: one Wishbone access per load/store, stalls until ack.
// Optional misalignment squash under CPU_MEMORY_ALIGN_CHECK_EN.
module cpu_memory
  import cpu_memory_pkg::*;
#(
  parameter int unsigned DWB_ADDR_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [PCB_WIDTH-1:0]      pipeline_control_bits_i,
  input  logic [REG_IDX_WIDTH-1:0]  register0_write_index_i,
  input  logic [REG_IDX_WIDTH-1:0]  register1_write_index_i,
  input  logic [DATA_WIDTH-1:0]     reg0_result_i,
  input  logic [DATA_WIDTH-1:0]     reg1_result_i,
  input  logic [DATA_WIDTH-1:0]     memory_address_i,
  input  logic [DATA_WIDTH-1:0]     mem_result_i,
  output logic                      register_wea_o,
  output logic                      register_web_o,
  output logic [REG_IDX_WIDTH-1:0]  register0_write_index_o,
  output logic [REG_IDX_WIDTH-1:0]  register1_write_index_o,
  output logic [DATA_WIDTH-1:0]     reg0_result_o,
  output logic [DATA_WIDTH-1:0]     reg1_result_o,
  output logic [PCB_WIDTH-1:0]      pipeline_control_bits_o,
  output logic                      stall_o,
  output logic                      align_error_o,
  output logic [DWB_ADDR_WIDTH-1:0] dwb_adr_o,
  output logic [DATA_WIDTH-1:0]     dwb_dat_o,
  input  logic [DATA_WIDTH-1:0]     dwb_dat_i,
  output logic                      dwb_we_o,
  output logic                      dwb_cyc_o,
  output logic                      dwb_stb_o,
  output logic [3:0]                dwb_sel_o,
  input  logic                      dwb_ack_i
);

  mem_instr_t                instr_in, instr_q;
  logic                      accept_c, mem_op_c, misaligned_c, req_c, done_c;
  logic [DATA_WIDTH-1:0]     rdata_c;
  logic [DWB_ADDR_WIDTH-1:0] bus_adr_c;

  assign instr_in = '{pcb:  pipeline_control_bits_i,
                      idx0: register0_write_index_i,
                      idx1: register1_write_index_i,
                      r0:   reg0_result_i,
                      r1:   reg1_result_i};

  // The stage only listens to execute while no bus cycle is open
  assign accept_c  = ~dwb_cyc_o;
  assign mem_op_c  = is_mem_op(pipeline_control_bits_i);
  assign bus_adr_c = DWB_ADDR_WIDTH'({memory_address_i[DATA_WIDTH-1:2], 2'b00});
  assign req_c     = accept_c & mem_op_c & ~misaligned_c;
  assign stall_o   = dwb_cyc_o;

`ifdef CPU_MEMORY_ALIGN_CHECK_EN
  assign misaligned_c = (memory_address_i[1:0] != 2'b00);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) align_error_o <= 1'b0;
    else        align_error_o <= accept_c & mem_op_c & misaligned_c;
  end
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^memory_address_i[1:0];
  assign misaligned_c    = 1'b0;
  assign align_error_o   = 1'b0;
`endif

  cpu_memory_wb_master #(.AW(DWB_ADDR_WIDTH)) u_wb_master (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req       (req_c),
    .we        (pipeline_control_bits_i[PCB_WM]),
    .adr       (bus_adr_c),
    .dat       (mem_result_i),
    .done_c    (done_c),
    .rdata_c   (rdata_c),
    .dwb_adr_o (dwb_adr_o),
    .dwb_dat_o (dwb_dat_o),
    .dwb_dat_i (dwb_dat_i),
    .dwb_we_o  (dwb_we_o),
    .dwb_cyc_o (dwb_cyc_o),
    .dwb_stb_o (dwb_stb_o),
    .dwb_sel_o (dwb_sel_o),
    .dwb_ack_i (dwb_ack_i)
  );

  // Write-back outputs: pass-through, bubble while a memory op is in flight, emit on ack
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      instr_q                 <= '0;
      pipeline_control_bits_o <= '0;
      register_wea_o          <= 1'b0;
      register_web_o          <= 1'b0;
      register0_write_index_o <= '0;
      register1_write_index_o <= '0;
      reg0_result_o           <= '0;
      reg1_result_o           <= '0;
    end else if (accept_c) begin
      register0_write_index_o <= register0_write_index_i;
      register1_write_index_o <= register1_write_index_i;
      reg0_result_o           <= reg0_result_i;
      reg1_result_o           <= reg1_result_i;
      if (mem_op_c) begin
        instr_q                 <= instr_in;
        pipeline_control_bits_o <= '0;
        register_wea_o          <= 1'b0;
        register_web_o          <= 1'b0;
      end else begin
        pipeline_control_bits_o <= pipeline_control_bits_i;
        register_wea_o          <= pipeline_control_bits_i[PCB_WA];
        register_web_o          <= pipeline_control_bits_i[PCB_WB];
      end
    end else if (done_c) begin
      pipeline_control_bits_o <= instr_q.pcb;
      register_wea_o          <= instr_q.pcb[PCB_WA];
      register_web_o          <= instr_q.pcb[PCB_WB];
      register0_write_index_o <= instr_q.idx0;
      register1_write_index_o <= instr_q.idx1;
      reg0_result_o           <= instr_q.pcb[PCB_WM] ? instr_q.r0 : rdata_c;
      reg1_result_o           <= instr_q.r1;
    end
  end

endmodule

// File: tb/tb_cpu_memory.sv
// Self-checking bench for cpu_memory: directed vector table, reset corner case,
// then randomized instructions against an instruction-level reference model.
module tb_cpu_memory;
  import cpu_memory_pkg::*;

  localparam logic [PCB_WIDTH-1:0] P_WA = 6'b000001;
  localparam logic [PCB_WIDTH-1:0] P_WB = 6'b000010;
  localparam logic [PCB_WIDTH-1:0] P_RM = 6'b000100;
  localparam logic [PCB_WIDTH-1:0] P_WM = 6'b001000;

  typedef struct {
    logic [PCB_WIDTH-1:0] pcb;
    logic [3:0]           i0, i1;
    logic [31:0]          r0, r1, addr, wdata, rdata;
    int                   waits;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [PCB_WIDTH-1:0] pcb_i;
  logic [3:0]  i0_i, i1_i;
  logic [31:0] r0_i, r1_i, addr_i, wdata_i, bus_rdata;
  logic        bus_ack;
  logic        wea, web, stall, align_err, we, cyc, stb;
  logic [3:0]  i0_o, i1_o, sel;
  logic [31:0] r0_o, r1_o, adr, dat;
  logic [PCB_WIDTH-1:0] pcb_o;

  int checks = 0;
  int errors = 0;
  vec_t vecs[6];

  cpu_memory dut (
    .clk_i(clk), .rst_i(rst_n),
    .pipeline_control_bits_i(pcb_i),
    .register0_write_index_i(i0_i), .register1_write_index_i(i1_i),
    .reg0_result_i(r0_i), .reg1_result_i(r1_i),
    .memory_address_i(addr_i), .mem_result_i(wdata_i),
    .register_wea_o(wea), .register_web_o(web),
    .register0_write_index_o(i0_o), .register1_write_index_o(i1_o),
    .reg0_result_o(r0_o), .reg1_result_o(r1_o),
    .pipeline_control_bits_o(pcb_o),
    .stall_o(stall), .align_error_o(align_err),
    .dwb_adr_o(adr), .dwb_dat_o(dat), .dwb_dat_i(bus_rdata),
    .dwb_we_o(we), .dwb_cyc_o(cyc), .dwb_stb_o(stb), .dwb_sel_o(sel),
    .dwb_ack_i(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    pcb_i = v.pcb; i0_i = v.i0; i1_i = v.i1; r0_i = v.r0; r1_i = v.r1;
    addr_i = v.addr; wdata_i = v.wdata;
  endtask

  task automatic scramble();
    pcb_i = PCB_WIDTH'($urandom); i0_i = 4'($urandom); i1_i = 4'($urandom);
    r0_i = $urandom; r1_i = $urandom; addr_i = $urandom; wdata_i = $urandom;
  endtask

  task automatic check_wb(input string tag, input logic [PCB_WIDTH-1:0] p, input logic [3:0] e0,
                          input logic [3:0] e1, input logic [31:0] v0, input logic [31:0] v1);
    chk({tag, ".pcb"}, 32'(pcb_o), 32'(p));
    chk({tag, ".wea"}, 32'(wea), 32'(p[PCB_WA]));
    chk({tag, ".web"}, 32'(web), 32'(p[PCB_WB]));
    chk({tag, ".idx0"}, 32'(i0_o), 32'(e0));
    chk({tag, ".idx1"}, 32'(i1_o), 32'(e1));
    chk({tag, ".r0"}, r0_o, v0);
    chk({tag, ".r1"}, r1_o, v1);
  endtask

  // Issue one instruction at a negedge and play bus slave; expectations come from
  // the instruction-level rules: loads return bus data in reg0, stores keep reg0.
  task automatic run(input string tag, input vec_t v);
    logic mem, is_store;
    logic [31:0] exp_adr;
    mem      = v.pcb[PCB_RM] | v.pcb[PCB_WM];
    is_store = v.pcb[PCB_WM];
    exp_adr  = v.addr & 32'hFFFF_FFFC;
    drive(v);
    bus_ack   = 1'($urandom);
    bus_rdata = $urandom;
    @(negedge clk);
    if (!mem) begin
      check_wb(tag, v.pcb, v.i0, v.i1, v.r0, v.r1);
      chk({tag, ".stall"}, 32'(stall), 32'd0);
      chk({tag, ".cyc"}, 32'(cyc), 32'd0);
      return;
    end
`ifdef CPU_MEMORY_ALIGN_CHECK_EN
    if (v.addr[1:0] != 2'b00) begin
      chk({tag, ".mis_cyc"}, 32'(cyc), 32'd0);
      chk({tag, ".mis_stall"}, 32'(stall), 32'd0);
      chk({tag, ".mis_err"}, 32'(align_err), 32'd1);
      chk({tag, ".mis_pcb"}, 32'(pcb_o), 32'd0);
      chk({tag, ".mis_wea"}, 32'(wea), 32'd0);
      pcb_i = '0;
      @(negedge clk);
      chk({tag, ".mis_err_end"}, 32'(align_err), 32'd0);
      return;
    end
`endif
    chk({tag, ".cyc"}, 32'(cyc), 32'd1);
    chk({tag, ".stb"}, 32'(stb), 32'd1);
    chk({tag, ".we"}, 32'(we), 32'(is_store));
    chk({tag, ".sel"}, 32'(sel), 32'hF);
    chk({tag, ".adr"}, adr, exp_adr);
    if (is_store) chk({tag, ".dat"}, dat, v.wdata);
    chk({tag, ".stall"}, 32'(stall), 32'd1);
    chk({tag, ".bubble"}, 32'(pcb_o), 32'd0);
    chk({tag, ".bubble_en"}, 32'({wea, web}), 32'd0);
    for (int w = 0; w <= v.waits; w++) begin
      bus_ack   = (w == v.waits);
      bus_rdata = bus_ack ? v.rdata : $urandom;
      scramble();
      @(negedge clk);
      if (w < v.waits) begin
        chk({tag, ".hold_cyc"}, 32'(cyc), 32'd1);
        chk({tag, ".hold_stall"}, 32'(stall), 32'd1);
        chk({tag, ".hold_adr"}, adr, exp_adr);
        chk({tag, ".hold_we"}, 32'(we), 32'(is_store));
        if (is_store) chk({tag, ".hold_dat"}, dat, v.wdata);
        chk({tag, ".hold_pcb"}, 32'(pcb_o), 32'd0);
      end
    end
    bus_ack = 1'b0;
    chk({tag, ".end_cyc"}, 32'({cyc, stb}), 32'd0);
    chk({tag, ".end_stall"}, 32'(stall), 32'd0);
    chk({tag, ".end_align"}, 32'(align_err), 32'd0);
    check_wb(tag, v.pcb, v.i0, v.i1, is_store ? v.r0 : v.rdata, v.r1);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{P_WA, 4'd3, 4'd0, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0, 0};
    vecs[1] = '{P_RM | P_WA, 4'd2, 4'd0, 32'h0, 32'h0, 32'h100, 32'h0, 32'hDEADBEEF, 0};
    vecs[2] = '{P_WM, 4'd0, 4'd0, 32'h55, 32'h0, 32'h200, 32'hCAFEF00D, 32'h0, 3};
    vecs[3] = '{P_RM | P_WA | P_WB, 4'd5, 4'd1, 32'h0, 32'h3FC, 32'h3F8, 32'h0, 32'hA5A5_0001, 1};
    vecs[4] = '{P_RM | P_WM | P_WA, 4'd7, 4'd8, 32'h77, 32'h88, 32'h40, 32'h1234, 32'hFFFF, 2};
    vecs[5] = '{P_RM | P_WA, 4'd9, 4'd0, 32'h0, 32'h0, 32'h102, 32'h0, 32'h0BAD_F00D, 0};

    pcb_i = '0; i0_i = '0; i1_i = '0; r0_i = '0; r1_i = '0;
    addr_i = '0; wdata_i = '0; bus_rdata = '0; bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.cyc_stb_stall", 32'({cyc, stb, stall}), 32'd0);
    chk("rst.adr", adr, 32'd0);
    chk("rst.dat", dat, 32'd0);
    chk("rst.wb", 32'({pcb_o, wea, web, align_err, we, sel}), 32'd0);
    chk("rst.r0", r0_o, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run($sformatf("vec%0d", i), vecs[i]);

    // Reset during an open bus cycle must drop the bus at once and lose the instruction
    v = '{P_RM | P_WA, 4'd4, 4'd0, 32'h0, 32'h0, 32'h300, 32'h0, 32'h0, 0};
    drive(v);
    @(negedge clk);
    chk("mid_rst.cyc_open", 32'(cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.bus_drop", 32'({cyc, stb, stall}), 32'd0);
    pcb_i = '0; r0_i = '0; bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst.no_wb", 32'({pcb_o, wea, web}), 32'd0);
    chk("mid_rst.no_cyc", 32'(cyc), 32'd0);
    bus_ack = 1'b0;

    for (int n = 0; n < 60; n++) begin
      v.pcb = PCB_WIDTH'($urandom);
      v.i0 = 4'($urandom); v.i1 = 4'($urandom);
      v.r0 = $urandom; v.r1 = $urandom; v.addr = $urandom;
      v.wdata = $urandom; v.rdata = $urandom;
      v.waits = $urandom_range(0, 3);
      run($sformatf("rnd%0d", n), v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_memory.md
# cpu_memory

Memory-access stage of the mox125 pipeline, directly downstream of the execute stage and upstream of write-back. It consumes execute's address, store data, register results and pipeline control bits. It runs at most one 32-bit data-bus transaction per instruction on a Wishbone classic master port and holds the pipeline with `stall_o` until the bus acknowledges. It then hands register results, including load data, to write-back.

## Interface
- `DWB_ADDR_WIDTH`, 32, data-bus address width; upper bits of `memory_address_i` beyond this are dropped.
- `clk_i`  in  1  pipeline clock, all state on rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `pipeline_control_bits_i`  in  `PCB_WIDTH`  from execute; uses `PCB_WA`, `PCB_WB`, `PCB_RM` (load), `PCB_WM` (store).
- `register0_write_index_i`, `register1_write_index_i`  in  4  destination register indices.
- `reg0_result_i`, `reg1_result_i`  in  32  register results from execute.
- `memory_address_i`  in  32  byte address of access.
- `mem_result_i`  in  32  store data.
- `register_wea_o`, `register_web_o`  out  1  write enables to write-back.
- `register0_write_index_o`, `register1_write_index_o`  out  4  passed-through indices.
- `reg0_result_o`, `reg1_result_o`  out  32  results; `reg0_result_o` carries load data on loads.
- `pipeline_control_bits_o`  out  `PCB_WIDTH`  to write-back; all-zero is a bubble.
- `stall_o`  out  1  stage busy; upstream holds its outputs while high.
- `align_error_o`  out  1  one-cycle misaligned-access pulse.
- `dwb_adr_o`  out  `DWB_ADDR_WIDTH`  bus address.
- `dwb_dat_o`  out  32  bus write data.
- `dwb_dat_i`  in  32  bus read data.
- `dwb_we_o`, `dwb_cyc_o`, `dwb_stb_o`  out  1  Wishbone controls.
- `dwb_sel_o`  out  4  byte lanes, always 4'b1111 during a cycle.
- `dwb_ack_i`  in  1  bus acknowledge.

## Operation
- The state machine has two states, `IDLE` and `BUS`.
- In `IDLE`, the stage samples inputs on every edge.
  - No `PCB_RM` or `PCB_WM` set: register all pass-through outputs. `register_wea_o`/`register_web_o` take `PCB_WA`/`PCB_WB`. Stay in `IDLE`.
  - `PCB_RM` or `PCB_WM` set: latch the whole instruction and drive `dwb_adr_o`, `dwb_dat_o` and `dwb_we_o` (= `PCB_WM`). Assert `dwb_cyc_o`, `dwb_stb_o` and `stall_o`, and enter `BUS`. Outputs to write-back become a bubble: pcb 0, enables 0.
  - `PCB_RM` and `PCB_WM` both set: treated as a store.
- In `BUS`, inputs are ignored and bus signals are held stable until `dwb_ack_i`.
- On an edge in `BUS` with `dwb_ack_i` = 1:
  - Deassert `cyc`, `stb` and `stall_o`, and return to `IDLE`.
  - Emit the latched instruction to write-back: pcb, enables, indices, `reg1_result`.
  - `reg0_result_o` takes `dwb_dat_i` for a load, or the latched `reg0_result` for a store.
- `dwb_ack_i` outside `BUS` is ignored.
- Back-to-back memory ops: the next op is accepted on the first `IDLE` edge after completion. There is no bus pipelining.

## Timing
- Reset values: all outputs 0, state `IDLE`; `dwb_dat_o` and `dwb_adr_o` are 0.
- Non-memory instruction: 1-cycle latency.
- Memory instruction accepted at edge N: the bus cycle is visible after N.
  - If ack is sampled at edge N+k (k ≥ 1), write-back sees the result after edge N+k.
  - Minimum latency is 2 cycles. `stall_o` is high for k cycles.
- Reset asserted mid-transaction: `cyc`/`stb` drop immediately (asynchronously) and the instruction is discarded, with no write-back.

## Configuration
- `CPU_MEMORY_ALIGN_CHECK_EN` defined:
  - A memory op with `memory_address_i[1:0]` ≠ 0 starts no bus cycle and is squashed (bubble to write-back).
  - `align_error_o` pulses for the one cycle after acceptance, and `stall_o` stays 0.
- `CPU_MEMORY_ALIGN_CHECK_EN` undefined:
  - `dwb_adr_o[1:0]` is forced to 0 and the access proceeds.
  - `align_error_o` is tied 0.

## Structure
- `PCB_*` bit indices and `PCB_WIDTH` stay in the shared `defines.v`.
- State encodings are local parameters.
- One natural sub-module, `cpu_memory_wb_master`: the `IDLE`/`BUS` Wishbone handshake FSM.
  - It takes an access request, address, data and direction.
  - It returns a done pulse and read data.

## Test plan
- ALU pass-through: pcb WA, index 3, `reg0_result_i` = 0x12345678 → next cycle `register_wea_o` = 1, index 3, value 0x12345678, `stall_o` = 0, no `cyc`.
- Load, ack after 0 waits: address 0x100, `dwb_dat_i` = 0xDEADBEEF → `cyc`/`stb` high 1 cycle with `we` = 0; result 0xDEADBEEF appears 2 cycles after issue; `stall_o` high 1 cycle.
- Store with 3 wait states: address 0x200, data 0xCAFEF00D → `dwb_we_o` = 1, `sel` = 1111; address and data stable 4 cycles; `stall_o` high 4 cycles; then pcb passes through.
- POP-style load: reg0 index 5, reg1 index 1 = 0x3FC, web set → after ack, reg0 = bus data and reg1 = 0x3FC, both enables honoured.
- Reset low during `BUS` → `cyc`/`stb`/`stall_o` 0 at once; no write-back after reset release.
- Misaligned load at 0x102:
  - with `CPU_MEMORY_ALIGN_CHECK_EN`: no `cyc`, one-cycle `align_error_o`, bubble;
  - without it: `dwb_adr_o` = 0x100.
